// File: rtl/pll_supervisor.sv
`default_nettype none
// ============================================================================
// pll_supervisor
//   PLL reset/lock supervisor: sequences pll_rst and holds sys_rst until the
//   synchronized lock has been stable. PLL_SUPERVISOR_RETRY_EN enables the lock
//   timeout with a saturating retry counter.
//   Rev 1.0 - initial release
// ============================================================================
module pll_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int CNT_W         = 16
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    input  logic       req_reset,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [3:0] retry_cnt,
    output logic       lock_lost
);

    typedef enum logic [1:0] {
        S_RESET  = 2'd0,
        S_WAIT   = 2'd1,
        S_STABLE = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    if (RST_CYCLES < 2 || STABLE_CYCLES < 1 || LOCK_TIMEOUT <= STABLE_CYCLES) begin : g_param_check
        $error("pll_supervisor: invalid parameter set");
    end

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               sync_q1;
    logic               lock_s;
    logic               lost_set;
    logic               timeout;

`ifdef PLL_SUPERVISOR_RETRY_EN
    logic [CNT_W-1:0]   to_cnt;
    logic               in_acquire;

    assign in_acquire = (state == S_WAIT) || (state == S_STABLE);
    assign timeout    = in_acquire && (to_cnt == CNT_W'(LOCK_TIMEOUT - 1));

    // retry_cnt only advances when the timeout actually wins over req_reset
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            to_cnt    <= '0;
            retry_cnt <= 4'd0;
        end else begin
            to_cnt <= (in_acquire && !timeout) ? to_cnt + 1'b1 : '0;
            if (timeout && !req_reset && retry_cnt != 4'd15)
                retry_cnt <= retry_cnt + 4'd1;
        end
    end
`else
    assign timeout   = 1'b0;
    assign retry_cnt = 4'd0;
`endif

    // cnt is shared: reset-pulse length in S_RESET, lock stability in S_STABLE
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lost_set  = 1'b0;
        if (req_reset) begin
            state_nxt = S_RESET;
            cnt_nxt   = '0;
            lost_set  = (state == S_RUN) && !lock_s;
        end else if (timeout) begin
            state_nxt = S_RESET;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_RESET: begin
                    if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (lock_s) begin
                        state_nxt = S_STABLE;
                        cnt_nxt   = '0;
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                        state_nxt = S_RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state_nxt = S_RESET;
                        cnt_nxt   = '0;
                        lost_set  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = S_RESET;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q1   <= 1'b0;
            lock_s    <= 1'b0;
            state     <= S_RESET;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            sync_q1   <= locked;
            lock_s    <= sync_q1;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pll_rst   <= (state_nxt == S_RESET);
            sys_rst   <= (state_nxt != S_RUN);
            ready     <= (state_nxt == S_RUN);
            if (lost_set)
                lock_lost <= 1'b1;
        end
    end

endmodule
`default_nettype wire
